// File: rtl/ps2_kbd_fifo_rx.sv
// PS/2 keyboard receiver: synchronised frame capture, E0/F0 prefix decoding,
// first-word-fall-through read FIFO and sticky error flags.
module ps2_kbd_fifo_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  input  logic             rd_en,
  input  logic             clr_err,
  output logic             valid,
  output logic [7:0]       data,
  output logic             ext,
  output logic             brk,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overflow,
  output logic [CNT_W-1:0] key_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR, S_STOP} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic [2:0]             bit_idx;
  logic [7:0]             shreg;
  logic                   par_bit;
  logic [TW-1:0]          to_cnt;
  logic                   ext_pend;
  logic                   brk_pend;

  logic [9:0]             mem [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;

  logic fall, bit_in, stop_ev, stop_err, par_err, good, is_e0, is_f0, push, timeout;
  logic empty, full, pop, do_push;

  // Older stage high, newer stage low: a falling edge seen once per clk.
  assign fall     = clk_sync[SYNC_STAGES-1] & ~clk_sync[SYNC_STAGES-2];
  assign bit_in   = dat_sync[SYNC_STAGES-2];

  assign stop_ev  = fall && (state == S_STOP);
  assign stop_err = stop_ev && !bit_in;
  assign par_err  = stop_ev && bit_in && !(^{shreg, par_bit});
  assign good     = stop_ev && bit_in && (^{shreg, par_bit});
  assign is_e0    = (shreg == 8'hE0);
  assign is_f0    = (shreg == 8'hF0);
  assign push     = good && !is_e0 && !is_f0;
  assign timeout  = (state != S_IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = rd_en && !empty;
  assign do_push  = push && (!full || pop);

  assign valid    = !empty;
  assign data     = empty ? 8'h00 : mem[rd_ptr[AW-1:0]][7:0];
  assign ext      = empty ? 1'b0  : mem[rd_ptr[AW-1:0]][9];
  assign brk      = empty ? 1'b0  : mem[rd_ptr[AW-1:0]][8];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sync   <= '1;
      dat_sync   <= '1;
      state      <= S_IDLE;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      to_cnt     <= '0;
      ext_pend   <= 1'b0;
      brk_pend   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};

      if (state == S_IDLE || fall) to_cnt <= '0;
      else                         to_cnt <= to_cnt + TW'(1);

      if (timeout) begin
        state <= S_IDLE;
      end else if (fall) begin
        case (state)
          S_IDLE: if (!bit_in) begin
            state   <= S_DATA;
            bit_idx <= '0;
          end
          S_DATA: begin
            shreg   <= {bit_in, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= S_PAR;
          end
          S_PAR: begin
            par_bit <= bit_in;
            state   <= S_STOP;
          end
          default: state <= S_IDLE;
        endcase
      end

      // Prefixes survive only until the next pushed code or any error.
      if (timeout || stop_err || par_err || push) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (good && is_e0) begin
        ext_pend <= 1'b1;
      end else if (good && is_f0) begin
        brk_pend <= 1'b1;
      end

      if (par_err)                 parity_err <= 1'b1;
      else if (clr_err)            parity_err <= 1'b0;
      if (stop_err || timeout)     frame_err  <= 1'b1;
      else if (clr_err)            frame_err  <= 1'b0;
      if (push && full && !pop)    overflow   <= 1'b1;
      else if (clr_err)            overflow   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      key_count <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= {ext_pend, brk_pend, shreg};
        wr_ptr              <= wr_ptr + PW'(1);
        if (!brk_pend) key_count <= key_count + CNT_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule
